bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter.sv | 97 +++++++++
 tb/tb_bram_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester round-robin arbiter for one single-port BRAM, with locked read-modify-write sequences
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req/we/lock/addr/wdata 0,1  requester access requests (lock holds ownership after the access)
//   gnt0, gnt1                  combinational grant, one BRAM access each
//   rvalid0, rvalid1, rdata     registered read-valid per requester; rdata is the BRAM output
//   mem_addr/mem_data/mem_we    BRAM port driven by the granted requester, zero when idle
//   mem_q                       BRAM read data, one cycle after the address
module bram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
    state_t state, state_n;
    logic [CW-1:0] lock_cnt, lock_cnt_n;
    // prio: requester favoured on contention in ARB (0 or 1)
    logic prio, prio_n;
    logic held;
    assign held     = (state == LOCK0 && lock0) || (state == LOCK1 && lock1);
    assign mem_we   = (gnt0 && we0) || (gnt1 && we1);
    assign mem_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    assign mem_data = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    assign rdata    = mem_q;
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_n    = state;
        lock_cnt_n = lock_cnt;
        prio_n     = prio;
        case (state)
            ARB: begin
                gnt0 = req0 && (!req1 || !prio);
                gnt1 = req1 && !gnt0;
            end
            LOCK0:   gnt0 = req0;
            LOCK1:   gnt1 = req1;
            default: state_n = ARB;
        endcase
        // the last-granted requester loses the next contention
        if (gnt0 || gnt1)
            prio_n = gnt0;
        if (state == ARB) begin
            if (LOCK_MAX > 1 && ((gnt0 && lock0) || (gnt1 && lock1))) begin
                state_n    = gnt0 ? LOCK0 : LOCK1;
                lock_cnt_n = CW'(1);
            end
        end else if (!held) begin
            state_n    = ARB;
            lock_cnt_n = '0;
        end else if (gnt0 || gnt1) begin
            lock_cnt_n = lock_cnt + CW'(1);
            if (lock_cnt_n == CW'(LOCK_MAX)) begin
                state_n    = ARB;
                lock_cnt_n = '0;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            lock_cnt <= '0;
            prio     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_cnt_n;
            prio     <= prio_n;
            rvalid0  <= gnt0 && !we0;
            rvalid1  <= gnt1 && !we1;
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: scoreboard bench for bram_arbiter with a behavioural ownership/memory model
module tb_bram_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int LM = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0, mem_addr;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, rdata, mem_data, mem_q;
    logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
    always #5 clk = ~clk;
    bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_data;
        mem_q <= bram[mem_addr];
    end
    typedef struct {
        logic g0, g1, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic rv0, rv1, rc;
        logic [DW-1:0] rd;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    // model: owner -1 = free arbitration, else locked to that requester
    int owner = -1;
    int held = 0;
    int fav = 0;
    logic pend[2] = '{1'b0, 1'b0};
    logic pend_known = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] ref_mem [int];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("gnt0", 32'(gnt0), 32'(e.g0));
            check("gnt1", 32'(gnt1), 32'(e.g1));
            check("mem_we", 32'(mem_we), 32'(e.we));
            check("mem_addr", 32'(mem_addr), 32'(e.a));
            check("mem_data", 32'(mem_data), 32'(e.d));
            check("rvalid0", 32'(rvalid0), 32'(e.rv0));
            check("rvalid1", 32'(rvalid1), 32'(e.rv1));
            if ((e.rv0 || e.rv1) && e.rc) check("rdata", 32'(rdata), 32'(e.rd));
        end
    end
    task automatic step(input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        exp_t e;
        int pick;
        logic rr[2], ww[2], ll[2];
        logic [AW-1:0] aa[2];
        logic [DW-1:0] dd[2];
        @(posedge clk);
        #1;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        rr = '{r0, r1}; ww = '{w0, w1}; ll = '{l0, l1}; aa = '{a0, a1}; dd = '{d0, d1};
        e.rv0 = pend[0]; e.rv1 = pend[1]; e.rc = pend_known; e.rd = pend_data;
        if (owner < 0) pick = (r0 && r1) ? fav : r0 ? 0 : r1 ? 1 : -1;
        else pick = rr[owner] ? owner : -1;
        e.g0 = (pick == 0);
        e.g1 = (pick == 1);
        e.we = 1'b0; e.a = '0; e.d = '0;
        pend[0] = 1'b0; pend[1] = 1'b0; pend_known = 1'b0;
        if (pick >= 0) begin
            e.we = ww[pick]; e.a = aa[pick]; e.d = dd[pick];
            if (ww[pick]) ref_mem[int'(aa[pick])] = dd[pick];
            else begin
                pend[pick] = 1'b1;
                pend_known = ref_mem.exists(int'(aa[pick]));
                if (pend_known) pend_data = ref_mem[int'(aa[pick])];
            end
            fav = 1 - pick;
        end
        if (owner < 0) begin
            if (pick >= 0 && ll[pick]) begin owner = pick; held = 1; end
        end else if (!ll[owner]) owner = -1;
        else if (pick >= 0) begin
            held++;
            if (held == LM) owner = -1;
        end
        sb.push_back(e);
    endtask
    task automatic idle();
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask
    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 7)), DW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 7)), DW'($urandom));
    endtask
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        #1;
        check("rst_rvalid0", 32'(rvalid0), 32'(0));
        check("rst_rvalid1", 32'(rvalid1), 32'(0));
        owner = -1; held = 0; fav = 0;
        pend[0] = 1'b0; pend[1] = 1'b0; pend_known = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask
    initial begin
        #3;
        check("reset_rvalid0", 32'(rvalid0), 32'(0));
        check("reset_rvalid1", 32'(rvalid1), 32'(0));
        check("reset_gnt", 32'({gnt0, gnt1}), 32'(0));
        check("reset_mem_we", 32'(mem_we), 32'(0));
        check("reset_mem_addr", 32'(mem_addr), 32'(0));
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (4) step(1, 0, 0, 10'h010, '0, 1, 0, 0, 10'h011, '0);
        idle();
        step(1, 0, 0, 10'h000, '0, 0, 0, 0, '0, '0);
        step(1, 1, 0, 10'h000, 16'h0005, 0, 0, 0, '0, '0);
        step(1, 0, 1, 10'h000, '0, 1, 0, 0, 10'h000, '0);
        step(1, 1, 1, 10'h000, 16'h0006, 1, 0, 0, 10'h000, '0);
        step(0, 0, 0, '0, '0, 1, 0, 0, 10'h000, '0);
        step(0, 0, 0, '0, '0, 1, 0, 0, 10'h000, '0);
        idle();
        step(1, 0, 0, 10'h001, '0, 0, 0, 0, '0, '0);
        repeat (6) step(1, 0, 0, 10'h002, '0, 1, 0, 1, 10'h003, '0);
        idle();
        step(0, 0, 0, '0, '0, 1, 1, 0, 10'h200, 16'h1234);
        step(1, 0, 0, 10'h200, '0, 0, 0, 0, '0, '0);
        idle();
        rand_steps(300);
        idle();
        step(1, 0, 1, 10'h004, '0, 0, 0, 0, '0, '0);
        step(1, 0, 1, 10'h005, '0, 1, 0, 0, 10'h006, '0);
        mid_reset();
        step(1, 0, 0, 10'h007, '0, 1, 0, 0, 10'h006, '0);
        rand_steps(200);
        idle();
        idle();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
